pipe_hazard_ctrl: RTL and testbench

- Pipeline control block that consumes the ID/EX stage outputs (control, destination, exception, PC fields) and the decode fields of the instruction in IF/ID.
- Drives PC/IF/ID write-enables, ID/EX bubble insertion, and stage flushes.
- Handles three cases: load-use stalls, multi-cycle mul/div issue holds, and exception flush sequencing with EPC capture.
- Sits beside the ID/EX register in the 5-stage pipeline.

---
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle of the hazard-control signals. The pipeline datapath
//                is the master: it drives decode and ID/EX fields and consumes
//                enables and flushes. The hazard controller is the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int PC_W = 8
);
    // IF/ID decode fields
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic            id_uses_rt;
    logic            id_is_muldiv;
    // ID/EX fields
    logic            ex_mem_read;
    logic [4:0]      ex_rt;
    logic            ex_exception;
    logic [PC_W-1:0] ex_pc;
    // Exception handler acknowledge
    logic            exc_ack;
    // Pipeline control outputs
    logic            pc_write;
    logic            ifid_write;
    logic            idex_bubble;
    logic            flush_ifid;
    logic            flush_idex;
    logic            flush_exmem;
    logic            pc_sel_exc;
    logic [PC_W-1:0] exc_vector;
    logic [PC_W-1:0] epc;
    logic            epc_valid;
    logic            muldiv_busy;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_muldiv,
        output ex_mem_read, ex_rt, ex_exception, ex_pc, exc_ack,
        input  pc_write, ifid_write, idex_bubble,
        input  flush_ifid, flush_idex, flush_exmem,
        input  pc_sel_exc, exc_vector, epc, epc_valid, muldiv_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_muldiv,
        input  ex_mem_read, ex_rt, ex_exception, ex_pc, exc_ack,
        output pc_write, ifid_write, idex_bubble,
        output flush_ifid, flush_idex, flush_exmem,
        output pc_sel_exc, exc_vector, epc, epc_valid, muldiv_busy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : 5-stage pipeline hazard controller. Generates PC/IF/ID write
//                enables, ID/EX bubbles and stage flushes for load-use stalls,
//                multi-cycle mul/div issue holds and exception flushes, and
//                captures the faulting PC (EPC).
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int              PC_W             = 8,
    parameter int              MULDIV_CYCLES    = 4,     // 2..15
    parameter int              EXC_FLUSH_CYCLES = 2,     // 1..7
    parameter logic [PC_W-1:0] EXC_VECTOR       = 8'h80
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipe_hazard_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_EXCF   = 2'd2
    } state_t;

    // Counter reload values: the entry cycle itself is the first stall/flush
    localparam logic [3:0] c_muldiv_load = 4'(MULDIV_CYCLES - 1);
    localparam logic [3:0] c_exc_load    = 4'(EXC_FLUSH_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic [PC_W-1:0] r_epc;
    logic            r_epc_valid;

    logic w_load_use;
    logic w_take_exc;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_bubble;
    logic w_flush_ifid;
    logic w_flush_idex;
    logic w_flush_exmem;
    logic w_pc_sel_exc;
    logic w_muldiv_busy;

    // Load in ID/EX whose destination is a source of the IF/ID instruction
    assign w_load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                        ((bus.ex_rt == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    // Next-state and output decode; exception beats load-use beats mul/div
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_take_exc    = 1'b0;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        w_pc_sel_exc  = 1'b0;
        w_muldiv_busy = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.ex_exception) begin
                    w_take_exc = 1'b1;
                end else if (w_load_use) begin
                    // Single bubble: the load leaves ID/EX next cycle
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                end else if (bus.id_is_muldiv) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_muldiv_busy = 1'b1;
                    w_cnt_nxt     = c_muldiv_load;
                    w_state_nxt   = ST_MULDIV;
                end
            end
            ST_MULDIV: begin
                if (bus.ex_exception) begin
                    w_take_exc = 1'b1;
                end else if (r_cnt != 4'd0) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_muldiv_busy = 1'b1;
                    w_cnt_nxt     = r_cnt - 4'd1;
                end else begin
                    // Release: the mul/div enters ID/EX at this edge
                    w_state_nxt = ST_RUN;
                end
            end
            ST_EXCF: begin
                // ex_exception is ignored: its source stage is being flushed
                w_ifid_write = 1'b0;
                w_flush_ifid = 1'b1;
                w_flush_idex = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        if (w_take_exc) begin
            w_pc_write    = 1'b1;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b0;
            w_muldiv_busy = 1'b0;
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
            w_flush_exmem = 1'b1;
            w_pc_sel_exc  = 1'b1;
            w_cnt_nxt     = c_exc_load;
            w_state_nxt   = ST_EXCF;
        end

        // Hold the pipeline frozen with a bubble while reset is asserted
        if (!rst_n) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_flush_ifid  = 1'b0;
            w_flush_idex  = 1'b0;
            w_flush_exmem = 1'b0;
            w_pc_sel_exc  = 1'b0;
            w_muldiv_busy = 1'b0;
        end
    end

    // State and hold/flush counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // EPC capture; exception entry wins over a simultaneous acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc       <= '0;
            r_epc_valid <= 1'b0;
        end else if (w_take_exc) begin
            r_epc       <= bus.ex_pc;
            r_epc_valid <= 1'b1;
        end else if (bus.exc_ack) begin
            r_epc_valid <= 1'b0;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.flush_ifid  = w_flush_ifid;
    assign bus.flush_idex  = w_flush_idex;
    assign bus.flush_exmem = w_flush_exmem;
    assign bus.pc_sel_exc  = w_pc_sel_exc;
    assign bus.muldiv_busy = w_muldiv_busy;
    assign bus.exc_vector  = EXC_VECTOR;
    assign bus.epc         = r_epc;
    assign bus.epc_valid   = r_epc_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//                followed by random traffic, compared against a cycle-level
//                behavioural model of stall/flush windows and EPC.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int         PC_W = 8;
    localparam int         MD   = 4;
    localparam int         EF   = 2;
    localparam logic [7:0] EV   = 8'h80;

    // Expected control vectors {pc_write, ifid_write, idex_bubble, flush_ifid,
    //                           flush_idex, flush_exmem, pc_sel_exc, muldiv_busy}
    localparam logic [7:0] c_v_reset = 8'b0010_0000;
    localparam logic [7:0] c_v_run   = 8'b1100_0000;
    localparam logic [7:0] c_v_lu    = 8'b0010_0000;
    localparam logic [7:0] c_v_md    = 8'b0010_0001;
    localparam logic [7:0] c_v_exc   = 8'b1001_1110;
    localparam logic [7:0] c_v_excf  = 8'b1001_1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.PC_W(PC_W)) bus ();

    pipe_hazard_ctrl #(
        .PC_W(PC_W), .MULDIV_CYCLES(MD), .EXC_FLUSH_CYCLES(EF), .EXC_VECTOR(EV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining post-entry flush cycles, remaining mul/div stall cycles
    int         m_flush_left;
    bit         m_md_active;
    int         m_md_rem;
    logic [7:0] m_epc;
    logic       m_epc_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_vec();
        return {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.flush_ifid,
                bus.flush_idex, bus.flush_exmem, bus.pc_sel_exc, bus.muldiv_busy};
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic muldiv, input logic memrd, input logic [4:0] ex_rt,
                          input logic exc, input logic [7:0] pc, input logic ack);
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rt   = uses_rt;
        bus.id_is_muldiv = muldiv;
        bus.ex_mem_read  = memrd;
        bus.ex_rt        = ex_rt;
        bus.ex_exception = exc;
        bus.ex_pc        = pc;
        bus.exc_ack      = ack;
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_md_active  = 0;
        m_md_rem     = 0;
        m_epc        = 8'h00;
        m_epc_valid  = 1'b0;
    endtask

    // One cycle: inputs already applied at the falling edge; check, then clock
    task automatic step(input string tag);
        logic [7:0] exp;
        int         nf, nmr;
        bit         nma, lu;
        logic [7:0] ne;
        logic       nv;
        lu  = bus.ex_mem_read && (bus.ex_rt != 0) &&
              ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        nf  = m_flush_left;
        nma = m_md_active;
        nmr = m_md_rem;
        ne  = m_epc;
        nv  = bus.exc_ack ? 1'b0 : m_epc_valid;
        if (m_flush_left > 0) begin
            exp = c_v_excf;
            nf  = m_flush_left - 1;
        end else if (bus.ex_exception) begin
            exp = c_v_exc;
            nf  = EF;
            nma = 0;
            ne  = bus.ex_pc;
            nv  = 1'b1;
        end else if (m_md_active) begin
            if (m_md_rem > 0) begin
                exp = c_v_md;
                nmr = m_md_rem - 1;
            end else begin
                exp = c_v_run;
                nma = 0;
            end
        end else if (lu) begin
            exp = c_v_lu;
        end else if (bus.id_is_muldiv) begin
            exp = c_v_md;
            nma = 1;
            nmr = MD - 1;
        end else begin
            exp = c_v_run;
        end
        #1;
        chk({tag, ":ctl"}, 32'(obs_vec()), 32'(exp));
        chk({tag, ":epc"}, 32'(bus.epc), 32'(m_epc));
        chk({tag, ":epc_valid"}, 32'(bus.epc_valid), 32'(m_epc_valid));
        @(posedge clk);
        m_flush_left = nf;
        m_md_active  = nma;
        m_md_rem     = nmr;
        m_epc        = ne;
        m_epc_valid  = nv;
        @(negedge clk);
    endtask

    // Assert reset between edges and verify the immediate effect
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ":ctl"}, 32'(obs_vec()), 32'(c_v_reset));
        chk({tag, ":epc"}, 32'(bus.epc), 32'h0);
        chk({tag, ":epc_valid"}, 32'(bus.epc_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        model_reset();
        idle();
        #2;
        chk("reset:ctl", 32'(obs_vec()), 32'(c_v_reset));
        chk("reset:epc", 32'(bus.epc), 32'h0);
        chk("reset:epc_valid", 32'(bus.epc_valid), 32'h0);
        chk("exc_vector", 32'(bus.exc_vector), 32'(EV));
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use via rs, then none once the load has moved on, then rt==0
        set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 8'h00, 1'b0); step("lu_rs");
        idle();                                                        step("lu_rs_after");
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0); step("lu_r0");

        // Load-use via rt gated by id_uses_rt
        set_in(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 8'h00, 1'b0); step("lu_rt_unused");
        set_in(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 8'h00, 1'b0); step("lu_rt_used");
        idle();                                                        step("lu_rt_after");

        // Mul/div held in IF/ID: four stalls, release in the fifth cycle
        set_in(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < MD + 1; i++) step("muldiv_hold");
        idle();                                                        step("muldiv_next");

        // Exception in RUN, flush window, then acknowledge
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'h24, 1'b0); step("exc_run");
        chk("exc_run:epc_cap", 32'(bus.epc), 32'h24);
        idle();
        for (int i = 0; i < EF; i++) step("exc_flush");
        step("exc_done");
        bus.exc_ack = 1'b1;                                            step("exc_ack");
        bus.exc_ack = 1'b0;                                            step("exc_ack_after");

        // Exception aborts a mul/div hold; a pulse during the flush is ignored
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0);
        step("md_entry");
        step("md_cnt3");
        bus.ex_exception = 1'b1; bus.ex_pc = 8'h40;                    step("md_exc");
        bus.id_is_muldiv = 1'b0; bus.ex_pc = 8'h55;                    step("excf_ignored");
        bus.ex_exception = 1'b0;                                       step("excf_last");
        chk("excf:epc_kept", 32'(bus.epc), 32'h40);
        step("excf_run");
        // Exception entry and acknowledge together: entry wins
        bus.ex_exception = 1'b1; bus.ex_pc = 8'h66; bus.exc_ack = 1'b1; step("exc_vs_ack");
        idle();
        for (int i = 0; i < EF; i++) step("exc2_flush");

        // Asynchronous reset mid-MULDIV and mid-EXCF
        bus.id_is_muldiv = 1'b1;                                       step("rst_md_entry");
        step("rst_md_hold");
        async_reset("rst_md");
        idle();                                                        step("rst_md_run");
        bus.ex_exception = 1'b1; bus.ex_pc = 8'h12;                    step("rst_exc_entry");
        bus.ex_exception = 1'b0;
        async_reset("rst_excf");
        step("rst_excf_run");

        // Random traffic on small register indices so hazards occur often
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 12) == 0),
                   8'($urandom), 1'($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
